// File: rtl/alu_ctrl_disp.sv
// ALU control decoder behind a one-entry valid/ready output register, with a saturating
// illegal-command counter and a static or scrolling seven-segment mnemonic display.
module alu_ctrl_disp #(
  parameter int unsigned NUM_DIGITS = 5,
  parameter int unsigned SCROLL_DIV = 25_000_000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              ALUOp,
  input  logic [5:0]              funct,
  input  logic                    scroll_en,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [3:0]              ALUcontrol,
  output logic                    illegal,
  output logic [7:0]              illegal_cnt,
  output logic [7*NUM_DIGITS-1:0] seg
);

  localparam int unsigned StrLen = NUM_DIGITS + 3;
  localparam int unsigned DivW   = $clog2(SCROLL_DIV);
  localparam int unsigned OffW   = $clog2(StrLen);
  localparam int unsigned IdxW   = OffW + 1;

  localparam logic [DivW-1:0] DivLast = DivW'(SCROLL_DIV - 1);
  localparam logic [OffW-1:0] OffLast = OffW'(StrLen - 1);
  localparam logic [IdxW-1:0] StrLenI = IdxW'(StrLen);

  localparam logic [6:0] GlyA     = 7'b0001000;
  localparam logic [6:0] GlyD     = 7'b1000010;
  localparam logic [6:0] GlyS     = 7'b0100100;
  localparam logic [6:0] GlyU     = 7'b1000001;
  localparam logic [6:0] GlyB     = 7'b1100000;
  localparam logic [6:0] GlyN     = 7'b1101010;
  localparam logic [6:0] GlyO     = 7'b0000001;
  localparam logic [6:0] GlyR     = 7'b1111010;
  localparam logic [6:0] GlyL     = 7'b1110001;
  localparam logic [6:0] GlyT     = 7'b1110000;
  localparam logic [6:0] GlyE     = 7'b0110000;
  localparam logic [6:0] GlyBlank = 7'b1111111;

  // Element [0] holds the leftmost character.
  function automatic logic [20:0] mk(input logic [6:0] c0, input logic [6:0] c1,
                                     input logic [6:0] c2);
    return {c2, c1, c0};
  endfunction

  logic                    accept;
  logic [3:0]              dec_ctrl;
  logic                    dec_ill;
  logic [2:0][6:0]         dec_mnem;

  logic                    out_valid_q, out_valid_d;
  logic [3:0]              ctrl_q, ctrl_d;
  logic                    ill_q, ill_d;
  logic [7:0]              cnt_q, cnt_d;
  logic [2:0][6:0]         mnem_q, mnem_d;
  logic [DivW-1:0]         div_q, div_d;
  logic [OffW-1:0]         off_q, off_d;
  logic [7*NUM_DIGITS-1:0] seg_q, seg_d;

  assign in_ready = !out_valid_q || out_ready;
  assign accept   = in_valid && in_ready;

  always_comb begin
    dec_ctrl = 4'b0010;
    dec_ill  = 1'b0;
    dec_mnem = mk(GlyA, GlyD, GlyD);
    unique case (ALUOp)
      2'b00: begin
        dec_ctrl = 4'b0010;
        dec_mnem = mk(GlyA, GlyD, GlyD);
      end
      2'b01: begin
        dec_ctrl = 4'b0110;
        dec_mnem = mk(GlyS, GlyU, GlyB);
      end
      2'b11: begin
        dec_ctrl = 4'b0000;
        dec_mnem = mk(GlyA, GlyN, GlyD);
      end
      2'b10: begin
        case (funct)
          6'b100000: begin dec_ctrl = 4'b0010; dec_mnem = mk(GlyA, GlyD, GlyD);     end
          6'b100010: begin dec_ctrl = 4'b0110; dec_mnem = mk(GlyS, GlyU, GlyB);     end
          6'b100100: begin dec_ctrl = 4'b0000; dec_mnem = mk(GlyA, GlyN, GlyD);     end
          6'b100101: begin dec_ctrl = 4'b0001; dec_mnem = mk(GlyO, GlyR, GlyBlank); end
          6'b101010: begin dec_ctrl = 4'b0111; dec_mnem = mk(GlyS, GlyL, GlyT);     end
          6'b100111: begin dec_ctrl = 4'b1100; dec_mnem = mk(GlyN, GlyO, GlyR);     end
          default: begin
            dec_ctrl = 4'b1111;
            dec_ill  = 1'b1;
            dec_mnem = mk(GlyE, GlyR, GlyR);
          end
        endcase
      end
      default: ;
    endcase
  end

  always_comb begin
    out_valid_d = out_valid_q;
    ctrl_d      = ctrl_q;
    ill_d       = ill_q;
    mnem_d      = mnem_q;
    cnt_d       = cnt_q;
    if (accept) begin
      out_valid_d = 1'b1;
      ctrl_d      = dec_ctrl;
      ill_d       = dec_ill;
      mnem_d      = dec_mnem;
      if (dec_ill && (cnt_q != 8'hFF)) begin
        cnt_d = cnt_q + 8'd1;
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // Scroll position restarts with every new result so the mnemonic always enters from c0.
  always_comb begin
    div_d = div_q + 1'b1;
    off_d = off_q;
    if (accept || !scroll_en) begin
      div_d = '0;
      off_d = '0;
    end else if (div_q == DivLast) begin
      div_d = '0;
      off_d = (off_q == OffLast) ? '0 : off_q + 1'b1;
    end
  end

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    localparam logic [IdxW-1:0] Pos = IdxW'(g);
    logic [IdxW-1:0] sum;
    logic [IdxW-1:0] idx;
    logic [6:0]      glyph;

    assign sum = scroll_en ? ({1'b0, off_q} + Pos) : Pos;
    assign idx = (sum >= StrLenI) ? (sum - StrLenI) : sum;

    always_comb begin
      glyph = GlyBlank;
      if (idx == IdxW'(0)) glyph = mnem_q[0];
      if (idx == IdxW'(1)) glyph = mnem_q[1];
      if (idx == IdxW'(2)) glyph = mnem_q[2];
    end

    assign seg_d[7*(NUM_DIGITS-g)-1 -: 7] = glyph;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= 4'b0000;
      ill_q       <= 1'b0;
      cnt_q       <= 8'd0;
      mnem_q      <= {3{GlyBlank}};
      div_q       <= '0;
      off_q       <= '0;
      seg_q       <= '1;
    end else begin
      out_valid_q <= out_valid_d;
      ctrl_q      <= ctrl_d;
      ill_q       <= ill_d;
      cnt_q       <= cnt_d;
      mnem_q      <= mnem_d;
      div_q       <= div_d;
      off_q       <= off_d;
      seg_q       <= seg_d;
    end
  end

  assign out_valid   = out_valid_q;
  assign ALUcontrol  = ctrl_q;
  assign illegal     = ill_q;
  assign illegal_cnt = cnt_q;
  assign seg         = seg_q;

endmodule

// File: doc/alu_ctrl_disp.md
ALU_CTRL_DISP -- requirements
Module: alu_ctrl_disp

Interface
Parameters:
REQ-001 SHALL have parameter NUM_DIGITS, default 5, meaning number of seven-segment digits driven (legal 3..8).
REQ-002 SHALL have parameter SCROLL_DIV, default 25_000_000, meaning clock cycles per scroll step (legal >=2).
Ports:
REQ-003 SHALL have clk  input  1  single clock; all state rising-edge.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous and active-low.
REQ-005 SHALL have in_valid  input  1  command present.
REQ-006 SHALL have in_ready  output  1  command accepted when in_valid && in_ready.
REQ-007 SHALL have ALUOp  input  2  main-control ALU opcode.
REQ-008 SHALL have funct  input  6  R-type function field.
REQ-009 SHALL have scroll_en  input  1  1 = scrolling display, 0 = static.
REQ-010 SHALL have out_valid  output  1  registered result present.
REQ-011 SHALL have out_ready  input  1  consumer takes result when out_valid && out_ready.
REQ-012 SHALL have ALUcontrol  output  4  registered ALU control code.
REQ-013 SHALL have illegal  output  1  registered; result came from unknown funct.
REQ-014 SHALL have illegal_cnt  output  8  saturating count of accepted illegal commands.
REQ-015 SHALL have seg  output  7*NUM_DIGITS  active-low segments; digit 0 = leftmost = seg[7*NUM_DIGITS-1 -: 7]; per digit bit6..bit0 = a..g.

Function
REQ-016 SHALL assert in_ready = !out_valid || out_ready (combinational, one-entry pipeline register).
REQ-017 SHALL, on accept, load out_valid=1, ALUcontrol, illegal, and mnemonic in the next clock edge (latency 1).
REQ-018 SHALL clear out_valid when out_ready && out_valid and no new accept that cycle; simultaneous pop and accept keeps out_valid=1 with new data.
REQ-019 SHALL decode: ALUOp 00 -> 0010 "Add"; 01 -> 0110 "Sub"; 11 -> 0000 "And"; 10 uses funct.
REQ-020 SHALL decode funct: 100000->0010 "Add"; 100010->0110 "Sub"; 100100->0000 "And"; 100101->0001 "Or"; 101010->0111 "SLt"; 100111->1100 "nOr".
REQ-021 SHALL, for ALUOp 10 with any other funct, output ALUcontrol=1111, illegal=1, mnemonic "Err".
REQ-022 SHALL increment illegal_cnt once per accepted illegal command, saturating at 255.
REQ-023 SHALL hold ALUcontrol, illegal, mnemonic unchanged while no accept occurs (including out_valid low).
REQ-024 SHALL use glyphs: A 0001000, d 1000010, S 0100100, U 1000001, b 1100000, n 1101010, O 0000001, r 1111010, L 1110001, t 1110000, E 0110000, blank 1111111; 2-char mnemonics pad with blank.
REQ-025 SHALL, static mode, show mnemonic chars c0..c2 on digits 0..2 and blank on digits 3..NUM_DIGITS-1.
REQ-026 SHALL, scroll mode, form string S = c0 c1 c2 followed by NUM_DIGITS blanks (length L=NUM_DIGITS+3); digit i shows S[(i+off) mod L].
REQ-027 SHALL advance off by 1 when divider counter reaches SCROLL_DIV-1 (counter then wraps to 0); off wraps L-1 -> 0.
REQ-028 SHALL reset divider and off to 0 on every accept and whenever scroll_en is 0.
REQ-029 SHALL register seg (one cycle after off/mnemonic change).

Reset
REQ-030 SHALL, while rst_n=0, force out_valid=0, ALUcontrol=0000, illegal=0, illegal_cnt=0, off=0, divider=0, mnemonic all blank, seg all 1s, regardless of clk.
REQ-031 SHALL discard any in-flight result when reset asserts mid-operation; first accept after release behaves per REQ-017.

Verification
REQ-032 SHALL verify: ALUOp=10 funct=100010 accepted, out_ready=1 -> next cycle out_valid=1 ALUcontrol=0110; two cycles later seg digits 0..2 = 0100100,1000001,1100000.
REQ-033 SHALL verify: out_ready=0 with out_valid=1 -> in_ready=0, second command ignored, ALUcontrol stable; out_ready=1 with new in_valid same cycle -> new result next cycle, out_valid stays 1.
REQ-034 SHALL verify: 300 accepted commands ALUOp=10 funct=000000 -> illegal=1, ALUcontrol=1111, illegal_cnt=255, seg "Err" = 0110000,1111010,1111010.
REQ-035 SHALL verify: SCROLL_DIV=4, NUM_DIGITS=5, "Or", scroll_en=1 -> off increments every 4 cycles, digit 0 shows O, r, blank x6, back to O after 32 cycles.
REQ-036 SHALL verify: rst_n low mid-scroll between clock edges -> seg=all 1s and out_valid=0 immediately, illegal_cnt=0.
